// File: rtl/lifo_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated LIFO: stack op encoding
// and width helpers used by the interface, the stack and the arbiter.
package lifo_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NONE = 2'd0;
  localparam op_t OP_PUSH = 2'd1;
  localparam op_t OP_POP  = 2'd2;

  // Requester index width; a single requester would still need one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy width must hold the value LIFO_SIZE itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lifo_rr_arbiter_if.sv
// Requester-side bus of the arbitrated LIFO: per-requester push/pop requests,
// grants, the tagged pop response and the stack status flags.
interface lifo_rr_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int LIFO_SIZE = 8
);
  localparam int ID_W  = lifo_pkg::id_width(N_REQ);
  localparam int CNT_W = lifo_pkg::cnt_width(LIFO_SIZE);

  logic [N_REQ-1:0]        req_push;
  logic [N_REQ-1:0]        req_pop;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;

  modport master (
    output req_push, req_pop, req_data,
    input  gnt, rsp_valid, rsp_id, rsp_data, count, full, empty
  );

  modport slave (
    input  req_push, req_pop, req_data,
    output gnt, rsp_valid, rsp_id, rsp_data, count, full, empty
  );
endinterface

// File: rtl/lifo_rr_arbiter_stack.sv
// Shift-register LIFO with the top word at index 0; executes at most one
// push or pop per cycle as commanded and tracks occupancy.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LIFO_SIZE = 8,
  parameter int CNT_W     = cnt_width(LIFO_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  op_t               op,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [LIFO_SIZE];

  // NOTE: storage is deliberately left out of reset; slots above count are
  // never observed, and a reset-free array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    case (op)
      OP_PUSH: begin
        mem[0] <= wdata;
        for (int i = 1; i < LIFO_SIZE; i++) mem[i] <= mem[i-1];
      end
      OP_POP: begin
        for (int i = 0; i < LIFO_SIZE - 1; i++) mem[i] <= mem[i+1];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (op == OP_PUSH)  count <= count + CNT_W'(1);
    else if (op == OP_POP)   count <= count - CNT_W'(1);
  end

  assign top = mem[0];

endmodule

// File: rtl/lifo_rr_arbiter.sv
// Round-robin arbiter granting one push or pop per cycle into a shared LIFO;
// popped words come back one cycle after the grant, tagged with the requester.
module lifo_rr_arbiter
  import lifo_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int LIFO_SIZE = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  lifo_rr_arbiter_if.slave bus
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = cnt_width(LIFO_SIZE);

  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] top;
  logic              full;
  logic              empty;
  logic [N_REQ-1:0]  elig;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   sel;
  logic              found;
  int                cand;
  op_t               op;
  logic [DATA_W-1:0] wdata;

  assign full  = (count == CNT_W'(LIFO_SIZE));
  assign empty = (count == '0);

  // Push outranks pop for the same requester; a blocked push also hides its pop.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_push[i]) elig[i] = !full;
      else                 elig[i] = bus.req_pop[i] && !empty;
    end
    elig = reset_n ? elig : '0;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(rr_ptr) + off) % N_REQ;
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    op    = OP_NONE;
    wdata = bus.req_data[int'(sel)*DATA_W +: DATA_W];
    if (found) op = bus.req_push[sel] ? OP_PUSH : OP_POP;
  end

  assign bus.gnt = found ? (N_REQ'(1) << sel) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rr_ptr <= '0;
    else if (found) rr_ptr <= (sel == ID_W'(N_REQ - 1)) ? '0 : sel + ID_W'(1);
  end

  // The popped word is the pre-edge top, captured alongside the grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= (op == OP_POP);
      if (op == OP_POP) begin
        bus.rsp_id   <= sel;
        bus.rsp_data <= top;
      end
    end
  end

  lifo_stack #(
    .DATA_W    (DATA_W),
    .LIFO_SIZE (LIFO_SIZE),
    .CNT_W     (CNT_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (reset_n),
    .op    (op),
    .wdata (wdata),
    .top   (top),
    .count (count)
  );

  assign bus.count = count;
  assign bus.full  = full;
  assign bus.empty = empty;

endmodule

// File: tb/tb_lifo_rr_arbiter.sv
// Directed bench for lifo_rr_arbiter: hand-computed grants, pop responses,
// occupancy and flags across ordering, full/empty and reset scenarios.
module tb_lifo_rr_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  lifo_rr_arbiter_if #(.N_REQ(4), .DATA_W(8), .LIFO_SIZE(8)) bus ();

  lifo_rr_arbiter #(.N_REQ(4), .DATA_W(8), .LIFO_SIZE(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    bus.req_data[i*8 +: 8] = d;
  endtask

  task automatic clear_reqs();
    bus.req_push = '0;
    bus.req_pop  = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_reqs();
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.req_push = '0;
    bus.req_pop  = '0;
    bus.req_data = '0;
    cyc();
    cyc();

    // Reset state, with a push pending that must not be granted yet.
    bus.req_push = 4'b0001;
    samp();
    check("rst_gnt",       bus.gnt, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id",    bus.rsp_id, 0);
    check("rst_rsp_data",  bus.rsp_data, 0);
    check("rst_count",     bus.count, 0);
    check("rst_empty",     bus.empty, 1);
    check("rst_full",      bus.full, 0);

    // Single requester: push 11,22,33 then pop three times.
    cyc();
    reset_n = 1'b1;
    set_data(0, 8'h11);
    samp(); check("t1_gnt_p0", bus.gnt, 4'b0001); check("t1_cnt0", bus.count, 0);
    cyc(); set_data(0, 8'h22);
    samp(); check("t1_gnt_p1", bus.gnt, 4'b0001); check("t1_cnt1", bus.count, 1);
    cyc(); set_data(0, 8'h33);
    samp(); check("t1_gnt_p2", bus.gnt, 4'b0001); check("t1_cnt2", bus.count, 2);
    cyc(); bus.req_push = 4'b0000; bus.req_pop = 4'b0001;
    samp(); check("t1_cnt3", bus.count, 3); check("t1_gnt_pop", bus.gnt, 4'b0001);
    check("t1_no_rsp", bus.rsp_valid, 0);
    cyc();
    samp(); check("t1_v0", bus.rsp_valid, 1); check("t1_d0", bus.rsp_data, 8'h33);
    check("t1_id0", bus.rsp_id, 0); check("t1_c2", bus.count, 2);
    cyc();
    samp(); check("t1_v1", bus.rsp_valid, 1); check("t1_d1", bus.rsp_data, 8'h22);
    check("t1_c1", bus.count, 1);
    cyc();
    samp(); check("t1_v2", bus.rsp_valid, 1); check("t1_d2", bus.rsp_data, 8'h11);
    check("t1_c0", bus.count, 0); check("t1_empty", bus.empty, 1);
    check("t1_gnt_empty", bus.gnt, 0);
    cyc(); clear_reqs();
    samp(); check("t1_v_end", bus.rsp_valid, 0);

    // All four push continuously: grants rotate 0,1,2,3 until full.
    cyc(); do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));
    bus.req_push = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      samp(); check($sformatf("t2_gnt%0d", k), bus.gnt, 4'b0001 << (k % 4));
      cyc();
    end
    samp(); check("t2_full", bus.full, 1); check("t2_cnt8", bus.count, 8);
    check("t2_gnt_full", bus.gnt, 0);
    cyc();
    samp(); check("t2_gnt_hold", bus.gnt, 0);

    // Full: requester 1 pops while 0 and 2 push; pop first, then requester 2.
    cyc();
    bus.req_push = 4'b0101; bus.req_pop = 4'b0010;
    samp(); check("t3_gnt_pop", bus.gnt, 4'b0010);
    cyc(); bus.req_pop = 4'b0000;
    samp(); check("t3_v", bus.rsp_valid, 1); check("t3_id", bus.rsp_id, 1);
    check("t3_d", bus.rsp_data, 8'hA3); check("t3_c7", bus.count, 7);
    check("t3_gnt_r2", bus.gnt, 4'b0100);
    cyc(); bus.req_push = 4'b0001;
    samp(); check("t3_c8", bus.count, 8); check("t3_gnt_full", bus.gnt, 0);
    check("t3_v_off", bus.rsp_valid, 0);

    // Empty: requester 3 pops and waits until requester 0 pushes 5A.
    cyc(); do_reset();
    bus.req_pop = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      samp(); check($sformatf("t4_idle_gnt%0d", k), bus.gnt, 0);
      check($sformatf("t4_idle_v%0d", k), bus.rsp_valid, 0);
      cyc();
    end
    bus.req_push = 4'b0001; set_data(0, 8'h5A);
    samp(); check("t4_gnt_push", bus.gnt, 4'b0001);
    cyc(); bus.req_push = 4'b0000;
    samp(); check("t4_gnt_pop", bus.gnt, 4'b1000); check("t4_c1", bus.count, 1);
    cyc(); bus.req_pop = 4'b0000;
    samp(); check("t4_v", bus.rsp_valid, 1); check("t4_id", bus.rsp_id, 3);
    check("t4_d", bus.rsp_data, 8'h5A); check("t4_c0", bus.count, 0);

    // Requester 2 asserts push and pop together: push wins, pop follows.
    cyc();
    bus.req_push = 4'b0100; bus.req_pop = 4'b0100; set_data(2, 8'h77);
    samp(); check("t5_gnt_push", bus.gnt, 4'b0100);
    cyc(); bus.req_push = 4'b0000;
    samp(); check("t5_gnt_pop", bus.gnt, 4'b0100); check("t5_c1", bus.count, 1);
    cyc(); bus.req_pop = 4'b0000;
    samp(); check("t5_v", bus.rsp_valid, 1); check("t5_d", bus.rsp_data, 8'h77);
    check("t5_id", bus.rsp_id, 2);

    // Reset pulsed in the cycle after a pop grant kills the response.
    cyc();
    bus.req_push = 4'b0001; set_data(0, 8'h99);
    samp(); check("t6_gnt_push", bus.gnt, 4'b0001);
    cyc(); bus.req_push = 4'b0000; bus.req_pop = 4'b0001;
    samp(); check("t6_gnt_pop", bus.gnt, 4'b0001);
    cyc();
    samp(); check("t6_v_pre", bus.rsp_valid, 1); check("t6_d_pre", bus.rsp_data, 8'h99);
    reset_n = 1'b0;
    #1;
    check("t6_v_rst", bus.rsp_valid, 0); check("t6_c_rst", bus.count, 0);
    check("t6_e_rst", bus.empty, 1);
    bus.req_pop = 4'b0000; bus.req_push = 4'b0001; set_data(0, 8'h01);
    cyc(); reset_n = 1'b1;
    samp(); check("t6_gnt_first", bus.gnt, 4'b0001);
    cyc(); bus.req_push = 4'b0000; bus.req_pop = 4'b0001;
    samp(); check("t6_c1", bus.count, 1); check("t6_gnt_pop", bus.gnt, 4'b0001);
    cyc(); clear_reqs();
    samp(); check("t6_v", bus.rsp_valid, 1); check("t6_d", bus.rsp_data, 8'h01);
    check("t6_id", bus.rsp_id, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
